// File: rtl/axi_read_slave_mem.sv
// AXI4 read-only slave over an internal word memory with a side preload port.
// Serves FIXED/INCR/WRAP bursts, one outstanding burst, 2-entry output buffer.
module axi_read_slave_mem #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH = 4096,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
    localparam int unsigned IDX_W = $clog2(MEM_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      arvalid,
    output logic                      arready,
    input  logic [AXI_ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]                arlen,
    input  logic [2:0]                arsize,
    input  logic [1:0]                arburst,
    output logic                      rvalid,
    input  logic                      rready,
    output logic [AXI_DATA_WIDTH-1:0] rdata,
    output logic [1:0]                rresp,
    output logic                      rlast,
    input  logic                      mem_we,
    input  logic [IDX_W-1:0]          mem_waddr,
    input  logic [AXI_DATA_WIDTH-1:0] mem_wdata
);

    typedef enum logic [1:0] {StIdle, StBurst, StDrain} state_e;

    localparam logic [AXI_ADDR_WIDTH-1:0] STEP = AXI_ADDR_WIDTH'(4);
    localparam logic [AXI_ADDR_WIDTH-1:0] WORDS = AXI_ADDR_WIDTH'(MEM_DEPTH);

    state_e                    state_q;
    logic                      arready_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]                len_q;
    logic [7:0]                beat_cnt_q;
    logic [1:0]                burst_q;
    logic                      burst_err_q;

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [AXI_DATA_WIDTH-1:0] buf_data_q [2];
    logic [1:0]                buf_resp_q [2];
    logic [1:0]                buf_last_q;
    logic                      rd_ptr_q;
    logic                      wr_ptr_q;
    logic [1:0]                count_q;

    logic                      pop;
    logic                      issue;
    logic                      beat_err;
    logic                      ar_err;
    logic [AXI_ADDR_WIDTH-1:0] word_idx;
    logic [AXI_ADDR_WIDTH-1:0] wrap_mask;
    logic [AXI_ADDR_WIDTH-1:0] addr_nxt;

    assign pop   = (count_q != 2'd0) && rready;
    // The read issued this cycle lands in the buffer at the edge, so leave room for it.
    assign issue = (state_q == StBurst) && ((count_q != 2'd2) || pop);

    assign word_idx = (addr_q - BASE_ADDR) >> 2;
    assign beat_err = burst_err_q || (addr_q < BASE_ADDR) || (word_idx >= WORDS);

    // Legal WRAP lengths are 2^k-1, so the byte mask is simply {len, 2'b11}.
    assign wrap_mask = {{(AXI_ADDR_WIDTH-10){1'b0}}, len_q, 2'b11};

    assign ar_err = (arsize != 3'd2) || (arburst == 2'b11) ||
                    ((arburst == 2'b10) && !((arlen == 8'd1) || (arlen == 8'd3) ||
                                             (arlen == 8'd7) || (arlen == 8'd15)));

    always_comb begin
        addr_nxt = addr_q + STEP;
        unique case (burst_q)
            2'b00:   addr_nxt = addr_q;
            2'b10:   addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + STEP) & wrap_mask);
            default: addr_nxt = addr_q + STEP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            arready_q   <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            burst_q     <= '0;
            burst_err_q <= 1'b0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= '0;
            buf_last_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_resp_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (arvalid && arready_q) begin
                        addr_q      <= araddr & ~AXI_ADDR_WIDTH'(3);
                        len_q       <= arlen;
                        beat_cnt_q  <= arlen;
                        burst_q     <= arburst;
                        burst_err_q <= ar_err;
                        arready_q   <= 1'b0;
                        state_q     <= StBurst;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                StBurst: begin
                    if (issue) begin
                        addr_q     <= addr_nxt;
                        beat_cnt_q <= beat_cnt_q - 8'd1;
                        if (beat_cnt_q == 8'd0) state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (pop && rlast) begin
                        state_q   <= StIdle;
                        arready_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (issue) begin
                buf_data_q[wr_ptr_q] <= beat_err ? '0 : mem[word_idx[IDX_W-1:0]];
                buf_resp_q[wr_ptr_q] <= beat_err ? 2'b10 : 2'b00;
                buf_last_q[wr_ptr_q] <= (beat_cnt_q == 8'd0);
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + 2'(issue) - 2'(pop);
        end
    end

    // Preload port; memory contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we && (int'(mem_waddr) < int'(MEM_DEPTH))) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign arready = arready_q;
    assign rvalid  = (count_q != 2'd0);
    assign rdata   = buf_data_q[rd_ptr_q];
    assign rresp   = buf_resp_q[rd_ptr_q];
    assign rlast   = buf_last_q[rd_ptr_q];

endmodule

// File: tb/tb_axi_read_slave_mem.sv
// Self-checking bench for axi_read_slave_mem: directed scenarios plus random bursts
// compared against a byte-address level model of the memory.
module tb_axi_read_slave_mem;

    localparam int unsigned DEPTH = 4096;

    logic        clk;
    logic        rst_n;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        mem_we;
    logic [11:0] mem_waddr;
    logic [31:0] mem_wdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] model_mem [DEPTH];

    logic [31:0] got_data [$];
    logic [1:0]  got_resp [$];
    logic        got_last [$];
    int          got_edge [$];
    int          stall_viol;
    int          arready_viol;
    int          ar_edge;
    logic        post_arready;

    axi_read_slave_mem #(
        .AXI_ADDR_WIDTH(32),
        .AXI_DATA_WIDTH(32),
        .MEM_DEPTH     (DEPTH),
        .BASE_ADDR     (32'h0000_0000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .arvalid  (arvalid),
        .arready  (arready),
        .araddr   (araddr),
        .arlen    (arlen),
        .arsize   (arsize),
        .arburst  (arburst),
        .rvalid   (rvalid),
        .rready   (rready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rlast    (rlast),
        .mem_we   (mem_we),
        .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected data/response of beat i, derived from byte addresses.
    function automatic void exp_beat(input logic [31:0] a0, input int len, input logic [2:0] size,
                                     input logic [1:0] burst, input int i,
                                     output logic [31:0] data, output logic [1:0] resp);
        logic [31:0] base;
        logic [31:0] lower;
        logic [31:0] addr;
        int          bytes;
        bit          bad;
        base  = a0 & ~32'h3;
        bytes = (len + 1) * 4;
        bad   = (size != 3'd2) || (burst == 2'b11);
        if (burst == 2'b10 && !(len inside {1, 3, 7, 15})) bad = 1'b1;
        case (burst)
            2'b00: addr = base;
            2'b01: addr = base + 32'(4 * i);
            2'b10: begin
                lower = base - (base % 32'(bytes));
                addr  = lower + ((base - lower + 32'(4 * i)) % 32'(bytes));
            end
            default: addr = base;
        endcase
        if (!bad && (addr >> 2) < 32'(DEPTH)) begin
            data = model_mem[addr >> 2];
            resp = 2'b00;
        end else begin
            data = 32'h0;
            resp = 2'b10;
        end
    endfunction

    // mode 0: rready always 1; 1: pattern 1,0,0,1; 2: random.
    task automatic run_burst(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input int mode);
        int          w;
        logic        prev_stall;
        logic [31:0] pd;
        logic [1:0]  pr;
        logic        pl;
        bit          done;
        got_data.delete();
        got_resp.delete();
        got_last.delete();
        got_edge.delete();
        stall_viol   = 0;
        arready_viol = 0;
        prev_stall   = 1'b0;
        pd = '0; pr = '0; pl = 1'b0;
        done = 1'b0;
        @(negedge clk);
        arvalid = 1'b1; araddr = a; arlen = len; arsize = size; arburst = burst; rready = 1'b0;
        w = 0;
        while (!arready && w < 20) begin
            @(negedge clk);
            w++;
        end
        ar_edge = cyc + 1;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge clk);
            arvalid = 1'b0;
            if (arready) arready_viol++;
            if (prev_stall && (rvalid !== 1'b1 || rdata !== pd || rresp !== pr || rlast !== pl))
                stall_viol++;
            case (mode)
                0:       rready = 1'b1;
                1:       rready = ((n % 4) == 0) || ((n % 4) == 3);
                default: rready = 1'($urandom_range(0, 1));
            endcase
            if (rvalid && rready) begin
                got_data.push_back(rdata);
                got_resp.push_back(rresp);
                got_last.push_back(rlast);
                got_edge.push_back(cyc + 1);
                if (rlast) done = 1'b1;
            end
            prev_stall = rvalid && !rready;
            pd = rdata; pr = rresp; pl = rlast;
        end
        @(negedge clk);
        rready = 1'b0;
        post_arready = arready;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({arready, rvalid, rdata, rresp, rlast} !== 36'h0) begin
            errors++;
            $display("FAIL reset_outputs got arready=%b rvalid=%b rdata=%h rresp=%b rlast=%b want all 0",
                     arready, rvalid, rdata, rresp, rlast);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (arready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_arready got %b want 1", arready);
        end
    endtask

    task automatic preload();
        logic [31:0] d;
        for (int i = 0; i < int'(DEPTH); i++) begin
            @(negedge clk);
            d = (i >= 'h40 && i < 'h48) ? 32'hA0 + 32'(i - 'h40) : $urandom;
            mem_we = 1'b1; mem_waddr = 12'(i); mem_wdata = d;
            model_mem[i] = d;
        end
        @(negedge clk);
        mem_we = 1'b0;
    endtask

    task automatic test_incr();
        run_burst(32'h100, 8'd7, 3'd2, 2'b01, 0);
        checks++;
        if (got_data.size() != 8) begin
            errors++;
            $display("FAIL incr_beats got %0d want 8", got_data.size());
        end
        for (int i = 0; i < got_data.size(); i++) begin
            checks++;
            if ({got_data[i], got_resp[i], got_last[i]} !== {32'hA0 + 32'(i), 2'b00, i == 7}) begin
                errors++;
                $display("FAIL incr_beat%0d got data=%h resp=%b last=%b want data=%h resp=00 last=%b",
                         i, got_data[i], got_resp[i], got_last[i], 32'hA0 + 32'(i), i == 7);
            end
            checks++;
            if (got_edge[i] != ar_edge + 2 + i) begin
                errors++;
                $display("FAIL incr_timing%0d got edge %0d want %0d", i, got_edge[i], ar_edge + 2 + i);
            end
        end
        checks++;
        if (post_arready !== 1'b1 || arready_viol != 0) begin
            errors++;
            $display("FAIL incr_arready got post=%b busy_high=%0d want post=1 busy_high=0",
                     post_arready, arready_viol);
        end
    endtask

    task automatic test_backpressure();
        run_burst(32'h100, 8'd7, 3'd2, 2'b01, 1);
        checks++;
        if (got_data.size() != 8 || stall_viol != 0) begin
            errors++;
            $display("FAIL bp_handshakes got beats=%0d unstable=%0d want beats=8 unstable=0",
                     got_data.size(), stall_viol);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            checks++;
            if ({got_data[i], got_resp[i], got_last[i]} !== {32'hA0 + 32'(i), 2'b00, i == 7}) begin
                errors++;
                $display("FAIL bp_beat%0d got data=%h resp=%b last=%b want data=%h last=%b",
                         i, got_data[i], got_resp[i], got_last[i], 32'hA0 + 32'(i), i == 7);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] want [4];
        want[0] = 32'hA3; want[1] = 32'hA0; want[2] = 32'hA1; want[3] = 32'hA2;
        run_burst(32'h10C, 8'd3, 3'd2, 2'b10, 2);
        checks++;
        if (got_data.size() != 4) begin
            errors++;
            $display("FAIL wrap_beats got %0d want 4", got_data.size());
        end
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            checks++;
            if ({got_data[i], got_resp[i], got_last[i]} !== {want[i], 2'b00, i == 3}) begin
                errors++;
                $display("FAIL wrap_beat%0d got data=%h resp=%b last=%b want data=%h last=%b",
                         i, got_data[i], got_resp[i], got_last[i], want[i], i == 3);
            end
        end
    endtask

    task automatic test_end_of_mem();
        logic [31:0] want [4];
        want[0] = model_mem[DEPTH-2]; want[1] = model_mem[DEPTH-1]; want[2] = '0; want[3] = '0;
        run_burst(32'((DEPTH - 2) * 4), 8'd3, 3'd2, 2'b01, 2);
        checks++;
        if (got_data.size() != 4) begin
            errors++;
            $display("FAIL eom_beats got %0d want 4", got_data.size());
        end
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            checks++;
            if ({got_data[i], got_resp[i], got_last[i]} !==
                {want[i], (i < 2) ? 2'b00 : 2'b10, i == 3}) begin
                errors++;
                $display("FAIL eom_beat%0d got data=%h resp=%b last=%b want data=%h resp=%b last=%b",
                         i, got_data[i], got_resp[i], got_last[i], want[i],
                         (i < 2) ? 2'b00 : 2'b10, i == 3);
            end
        end
    endtask

    task automatic test_errors();
        run_burst(32'h100, 8'd1, 3'd1, 2'b01, 0);
        checks++;
        if (got_data.size() != 2) begin
            errors++;
            $display("FAIL size_err_beats got %0d want 2", got_data.size());
        end
        for (int i = 0; i < got_data.size(); i++) begin
            checks++;
            if ({got_data[i], got_resp[i], got_last[i]} !== {32'h0, 2'b10, i == 1}) begin
                errors++;
                $display("FAIL size_err_beat%0d got data=%h resp=%b last=%b want 0/10/%b",
                         i, got_data[i], got_resp[i], got_last[i], i == 1);
            end
        end
        run_burst(32'h100, 8'd0, 3'd2, 2'b11, 0);
        checks++;
        if (got_data.size() != 1) begin
            errors++;
            $display("FAIL burst11_beats got %0d want 1", got_data.size());
        end else begin
            checks++;
            if ({got_data[0], got_resp[0], got_last[0]} !== {32'h0, 2'b10, 1'b1}) begin
                errors++;
                $display("FAIL burst11_beat got data=%h resp=%b last=%b want 0/10/1",
                         got_data[0], got_resp[0], got_last[0]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] ed;
        logic [1:0]  er;
        int          bt;
        int          wl [4];
        wl[0] = 1; wl[1] = 3; wl[2] = 7; wl[3] = 15;
        for (int t = 0; t < 40; t++) begin
            bt    = int'($urandom_range(0, 9));
            burst = (bt < 3) ? 2'b00 : (bt < 6) ? 2'b01 : (bt < 9) ? 2'b10 : 2'b11;
            if (burst == 2'b10 && $urandom_range(0, 4) != 0) len = 8'(wl[$urandom_range(0, 3)]);
            else len = 8'($urandom_range(0, 15));
            size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            addr = 32'($urandom_range(0, DEPTH + 15)) * 4 + 32'($urandom_range(0, 3));
            run_burst(addr, len, size, burst, 2);
            checks++;
            if (got_data.size() != int'(len) + 1 || stall_viol != 0 || post_arready !== 1'b1) begin
                errors++;
                $display("FAIL rand%0d_shape got beats=%0d unstable=%0d arready=%b want %0d/0/1",
                         t, got_data.size(), stall_viol, post_arready, int'(len) + 1);
            end
            for (int i = 0; i < got_data.size(); i++) begin
                exp_beat(addr, int'(len), size, burst, i, ed, er);
                checks++;
                if ({got_data[i], got_resp[i], got_last[i]} !== {ed, er, i == int'(len)}) begin
                    errors++;
                    $display("FAIL rand%0d_beat%0d a=%h len=%0d sz=%0d b=%b got %h/%b/%b want %h/%b/%b",
                             t, i, addr, len, size, burst, got_data[i], got_resp[i], got_last[i],
                             ed, er, i == int'(len));
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int beats;
        int n;
        @(negedge clk);
        arvalid = 1'b1; araddr = 32'h100; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        arvalid = 1'b0;
        rready  = 1'b1;
        beats = 0;
        n = 0;
        while (!(rvalid && beats == 3) && n < 50) begin
            if (rvalid) beats++;
            @(negedge clk);
            n++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0 || rlast !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs got rvalid=%b rlast=%b want 0/0", rvalid, rlast);
        end
        rst_n  = 1'b1;
        rready = 1'b0;
        @(negedge clk);
        checks++;
        if (arready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_arready got %b want 1", arready);
        end
        run_burst(32'h100, 8'd7, 3'd2, 2'b01, 0);
        checks++;
        if (got_data.size() != 8 || got_data[0] !== 32'hA0) begin
            errors++;
            $display("FAIL midreset_rerun got beats=%0d first=%h want 8/000000a0",
                     got_data.size(), (got_data.size() > 0) ? got_data[0] : 32'hx);
        end
    endtask

    initial begin
        arvalid = 1'b0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01;
        rready = 1'b0; mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0; rst_n = 1'b0;
        test_reset();
        preload();
        test_incr();
        test_backpressure();
        test_wrap();
        test_end_of_mem();
        test_errors();
        test_random();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
